lifting_dwt_1d: RTL and testbench

LIFTING_DWT_1D -- requirements
Module: lifting_dwt_1d

---
 rtl/lifting_dwt_1d.sv | 175 +++++++++++++++++
 tb/tb_lifting_dwt_1d.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lifting_dwt_1d.sv
`default_nettype none
// ============================================================================
//  Module      : lifting_dwt_1d
//  Description : One-level 1-D integer wavelet transform of a pixel line.
//                Haar (mode=0) or LeGall 5/3 (mode=1) lifting with symmetric
//                boundary extension, one input sample per cycle and one
//                registered output pair stage with valid/ready flow control.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                mode                    - transform select, latched at line start
//                in_valid/in_ready       - input handshake
//                in_data, in_last        - unsigned pixel, end-of-line marker
//                out_valid/out_ready     - output handshake
//                out_low, out_high       - s[k], d[k] (two's complement, DW+2 bits)
//                out_last                - final pair of the line
//                err                     - one-cycle pulse on odd-length line
//  Revision    : 1.0 - initial release
// ============================================================================
module lifting_dwt_1d #(
    parameter int DW = 8,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW+1:0] out_low,
    output logic [DW+1:0] out_high,
    output logic          out_last,
    output logic          err
);

    localparam int W = DW + 2;
    localparam logic signed [W-1:0] C_TWO = W'(2);

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ODD   = 2'd1,
        ST_EVEN  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [CW-1:0]         r_count;
    logic signed [W-1:0]   r_even;     // even[k] of the pair being built
    logic signed [W-1:0]   r_odd;      // odd[k], LeGall waits for even[k+1]
    logic signed [W-1:0]   r_dprev;    // d[k-1]
    logic                  r_have_d;   // r_dprev holds a valid d[k-1]
    logic                  r_valid;
    logic                  r_last;
    logic                  r_err;
    logic signed [W-1:0]   r_low;
    logic signed [W-1:0]   r_high;

    logic                  w_acc;
    logic                  w_odd_pos;
    logic                  w_pair;
    logic                  w_err;
    logic signed [W-1:0]   w_x;
    logic signed [W-1:0]   w_haar_d;
    logic signed [W-1:0]   w_haar_s;
    logic signed [W-1:0]   w_lg_next_even;
    logic signed [W-1:0]   w_lg_odd;
    logic signed [W-1:0]   w_lg_esum;
    logic signed [W-1:0]   w_lg_d;
    logic signed [W-1:0]   w_lg_dp;
    logic signed [W-1:0]   w_lg_dsum;
    logic signed [W-1:0]   w_lg_s;
    logic signed [W-1:0]   w_s;
    logic signed [W-1:0]   w_d;

    assign in_ready  = !r_valid || out_ready;
    assign w_acc     = in_valid && in_ready;
    assign w_x       = $signed({2'b00, in_data});
    // Position parity within the line; the counter is reset on every line
    // end, and its LSB stays correct across wrap because 2^CW is even.
    assign w_odd_pos = r_count[0];

    // Haar lifting on (even[k], odd[k]) when odd[k] arrives.
    assign w_haar_d = w_x - r_even;
    assign w_haar_s = r_even + (w_haar_d >>> 1);

    // LeGall lifting for pair k. In EVEN state the incoming sample is
    // even[k+1] and odd[k] is registered; on a last odd sample the incoming
    // sample is odd[K-1] and even[K] mirrors even[K-1].
    assign w_lg_next_even = (r_state == ST_ODD) ? r_even : w_x;
    assign w_lg_odd       = (r_state == ST_ODD) ? w_x : r_odd;
    assign w_lg_esum      = r_even + w_lg_next_even;
    assign w_lg_d         = w_lg_odd - (w_lg_esum >>> 1);
    assign w_lg_dp        = r_have_d ? r_dprev : w_lg_d;   // d[-1] = d[0]
    assign w_lg_dsum      = w_lg_dp + w_lg_d + C_TWO;
    assign w_lg_s         = r_even + (w_lg_dsum >>> 2);

    assign w_s = r_mode ? w_lg_s : w_haar_s;
    assign w_d = r_mode ? w_lg_d : w_haar_d;

    // A pair leaves on: any odd sample in Haar; in LeGall, a non-final even
    // sample (k>=1) or the final odd sample. A final even sample yields err.
    assign w_pair = (r_state == ST_ODD && (!r_mode || in_last)) ||
                    (r_state == ST_EVEN && r_mode && !in_last);
    assign w_err  = w_acc && in_last && !w_odd_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FIRST;
            r_mode   <= 1'b0;
            r_count  <= '0;
            r_even   <= '0;
            r_odd    <= '0;
            r_dprev  <= '0;
            r_have_d <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
            r_low    <= '0;
            r_high   <= '0;
        end else begin
            r_err <= w_err;

            if (w_acc && w_pair) begin
                r_valid <= 1'b1;
                r_low   <= w_s;
                r_high  <= w_d;
                r_last  <= in_last;
            end else if (out_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            if (w_acc) begin
                if (in_last) begin
                    // Line complete or aborted: drop all line history.
                    r_state  <= ST_FIRST;
                    r_count  <= '0;
                    r_have_d <= 1'b0;
                end else begin
                    r_count <= r_count + 1'b1;
                    case (r_state)
                        ST_FIRST: begin
                            r_mode   <= mode;
                            r_even   <= w_x;
                            r_have_d <= 1'b0;
                            r_state  <= ST_ODD;
                        end
                        ST_ODD: begin
                            r_odd   <= w_x;
                            r_state <= ST_EVEN;
                        end
                        ST_EVEN: begin
                            r_even  <= w_x;
                            r_state <= ST_ODD;
                            if (r_mode) begin
                                r_dprev  <= w_lg_d;
                                r_have_d <= 1'b1;
                            end
                        end
                        default: r_state <= ST_FIRST;
                    endcase
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_low   = r_low;
    assign out_high  = r_high;
    assign out_last  = r_last;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lifting_dwt_1d.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifting_dwt_1d
//  Description : Directed, table-driven self-checking bench for lifting_dwt_1d
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifting_dwt_1d;

    localparam int DW = 8;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW+1:0] out_low;
    logic [DW+1:0] out_high;
    logic          out_last;
    logic          err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lifting_dwt_1d #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_low  (out_low),
        .out_high (out_high),
        .out_last (out_last),
        .err      (err)
    );

    typedef struct {
        string name;
        logic  md;
        int    data;
        logic  last;
        logic  ev;
        int    lo;
        int    hi;
        logic  el;
        logic  ee;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic ev, input int lo,
                         input int hi, input logic el, input logic ee);
        logic [DW+1:0] elo;
        logic [DW+1:0] ehi;
        elo = lo[DW+1:0];
        ehi = hi[DW+1:0];
        tests++;
        if (out_valid !== ev || err !== ee ||
            (ev && (out_low !== elo || out_high !== ehi || out_last !== el))) begin
            fails++;
            $display("FAIL %s: got valid=%0b low=%0d high=%0d last=%0b err=%0b, want valid=%0b low=%0d high=%0d last=%0b err=%0b",
                     name, out_valid, $signed(out_low), $signed(out_high), out_last, err,
                     ev, lo, hi, el, ee);
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        tests++;
        if (in_ready !== exp) begin
            fails++;
            $display("FAIL %s: got in_ready=%0b, want %0b", name, in_ready, exp);
        end
    endtask

    // Present one sample for one clock edge, leave the bench #1 after it.
    task automatic drive(input logic md, input int data, input logic last);
        mode     = md;
        in_data  = data[DW-1:0];
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1;

        // Haar 10,20
        tbl.push_back('{"haar2_s0", 0, 10,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"haar2_s1", 0, 20,  1, 1,  15,   10, 1, 0});
        // Haar 9,4,200,0
        tbl.push_back('{"haar4_s0", 0,  9,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"haar4_s1", 0,  4,  0, 1,   6,   -5, 0, 0});
        tbl.push_back('{"haar4_s2", 0, 200, 0, 0,   0,    0, 0, 0});
        tbl.push_back('{"haar4_s3", 0,  0,  1, 1, 100, -200, 1, 0});
        // LeGall 10,20,30,40
        tbl.push_back('{"lg4_s0",   1, 10,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg4_s1",   1, 20,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg4_s2",   1, 30,  0, 1,  10,    0, 0, 0});
        tbl.push_back('{"lg4_s3",   1, 40,  1, 1,  33,   10, 1, 0});
        // Haar odd-length line 5,7,9 then line 1,3
        tbl.push_back('{"odd_s0",   0,  5,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"odd_s1",   0,  7,  0, 1,   6,    2, 0, 0});
        tbl.push_back('{"odd_s2",   0,  9,  1, 0,   0,    0, 0, 1});
        tbl.push_back('{"after_s0", 0,  1,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"after_s1", 0,  3,  1, 1,   2,    2, 1, 0});
        // LeGall line with mode dropping to 0 mid-line: must stay LeGall
        tbl.push_back('{"mchg_s0",  1, 10,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"mchg_s1",  0, 20,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"mchg_s2",  0, 30,  0, 1,  10,    0, 0, 0});
        tbl.push_back('{"mchg_s3",  0, 40,  1, 1,  33,   10, 1, 0});
        // LeGall 8,2,4,6,0,4: negative d and floor shifts
        tbl.push_back('{"lg6_s0",   1,  8,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg6_s1",   1,  2,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg6_s2",   1,  4,  0, 1,   6,   -4, 0, 0});
        tbl.push_back('{"lg6_s3",   1,  6,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg6_s4",   1,  0,  0, 1,   4,    4, 0, 0});
        tbl.push_back('{"lg6_s5",   1,  4,  1, 1,   2,    4, 1, 0});
        // Single-sample line is odd-length
        tbl.push_back('{"single",   0, 77,  1, 0,   0,    0, 0, 1});
        // LeGall two-sample line: d[-1]=d[0]=10, s=10+((10+10+2)>>>2)=15
        tbl.push_back('{"lg2_s0",   1, 10,  0, 0,   0,    0, 0, 0});
        tbl.push_back('{"lg2_s1",   1, 20,  1, 1,  15,   10, 1, 0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 0, 0, 0, 0, 0);
        tests++;
        if (out_low !== '0 || out_high !== '0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: got low=%0d high=%0d last=%0b, want 0 0 0",
                     $signed(out_low), $signed(out_high), out_last);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_ready("ready_after_reset", 1'b1);

        foreach (tbl[i]) begin
            drive(tbl[i].md, tbl[i].data, tbl[i].last);
            check(tbl[i].name, tbl[i].ev, tbl[i].lo, tbl[i].hi, tbl[i].el, tbl[i].ee);
        end

        // Backpressure: hold a pending Haar pair for 5 cycles with 200 waiting
        drive(0, 9, 0);
        check("stall_s0", 0, 0, 0, 0, 0);
        drive(0, 4, 0);
        check("stall_s1", 1, 6, -5, 0, 0);
        out_ready = 1'b0;
        mode      = 1'b0;
        in_data   = 8'd200;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_hold", 1, 6, -5, 0, 0);
            check_ready("stall_ready", 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall_release", 0, 0, 0, 0, 0);
        drive(0, 0, 1);
        check("stall_s3", 1, 100, -200, 1, 0);

        // Reset mid-line in LeGall, then a fresh two-sample line
        drive(1, 10, 0);
        drive(1, 20, 0);
        drive(1, 30, 0);
        check("midrst_pre", 1, 10, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_clear", 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_ready("midrst_ready", 1'b1);
        drive(1, 10, 0);
        check("midrst_s0", 0, 0, 0, 0, 0);
        drive(1, 20, 1);
        check("midrst_s1", 1, 15, 10, 1, 0);
        @(posedge clk);
        #1;
        check("midrst_idle", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
